// File: rtl/up_cnt_sched_if.sv
// Request/grant bundle between the requesters and up_cnt_sched.
// The requester side uses the master modport and the scheduler uses the slave modport.
interface up_cnt_sched_if #(
  parameter int CNT_W = 3,
  parameter int LEN_W = 3
);
  logic             req0;
  logic [LEN_W-1:0] len0;
  logic             req1;
  logic [LEN_W-1:0] len1;
  logic             clear;
  logic             gnt0;
  logic             gnt1;
  logic             done0;
  logic             done1;
  logic             busy;
  logic [CNT_W-1:0] up_cnt;
  logic             wrap;

  modport master (
    output req0, len0, req1, len1, clear,
    input  gnt0, gnt1, done0, done1, busy, up_cnt, wrap
  );

  modport slave (
    input  req0, len0, req1, len1, clear,
    output gnt0, gnt1, done0, done1, busy, up_cnt, wrap
  );
endinterface

// File: rtl/up_cnt_sched.sv
// Two-requester burst scheduler in front of a modulo-(CNT_MAX+1) up-counter.
// Define UP_CNT_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module up_cnt_sched #(
  parameter int CNT_W   = 3,
  parameter int CNT_MAX = 6,
  parameter int LEN_W   = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  up_cnt_sched_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(CNT_MAX);
  localparam logic [LEN_W-1:0] ONE_L = LEN_W'(1);

  state_t           state_q;
  logic             owner_q;
  logic [LEN_W-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             done0_q;
  logic             done1_q;
  logic             busy_q;
  logic             wrap_q;
`ifndef UP_CNT_SCHED_FIXED_PRIO_EN
  logic             last_q;
`endif

  logic             pick_valid_d;
  logic             pick_d;
  logic [LEN_W-1:0] pick_len_d;
  logic             owner_req_d;
  logic [CNT_W-1:0] cnt_inc_d;

  // Arbitration choice and next counter value.
  always_comb begin
    pick_valid_d = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
`ifdef UP_CNT_SCHED_FIXED_PRIO_EN
      pick_d = 1'b0;
`else
      pick_d = ~last_q;
`endif
    end else if (bus.req1) begin
      pick_d = 1'b1;
    end else begin
      pick_d = 1'b0;
    end
    pick_len_d  = pick_d ? bus.len1 : bus.len0;
    owner_req_d = owner_q ? bus.req1 : bus.req0;
    if (cnt_q == MAX_V) begin
      cnt_inc_d = '0;
    end else begin
      cnt_inc_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Grant/burst FSM with registered outputs and the shared counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      wrap_q  <= 1'b0;
`ifndef UP_CNT_SCHED_FIXED_PRIO_EN
      last_q  <= 1'b1;
`endif
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      wrap_q  <= 1'b0;
      if (bus.clear) begin
        cnt_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (pick_valid_d) begin
            owner_q <= pick_d;
            gnt0_q  <= ~pick_d;
            gnt1_q  <= pick_d;
            rem_q   <= pick_len_d;
            busy_q  <= 1'b1;
            if (pick_len_d == '0) begin
              state_q <= FIN;
              done0_q <= ~pick_d;
              done1_q <= pick_d;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          // Owner withdrawal aborts silently; CLEAR only stalls the burst.
          if (!owner_req_d) begin
            state_q <= IDLE;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifndef UP_CNT_SCHED_FIXED_PRIO_EN
            last_q  <= owner_q;
`endif
          end else if (!bus.clear) begin
            cnt_q  <= cnt_inc_d;
            wrap_q <= (cnt_q == MAX_V);
            rem_q  <= rem_q - ONE_L;
            if (rem_q == ONE_L) begin
              state_q <= FIN;
              done0_q <= ~owner_q;
              done1_q <= owner_q;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          busy_q  <= 1'b0;
`ifndef UP_CNT_SCHED_FIXED_PRIO_EN
          last_q  <= owner_q;
`endif
        end
        default: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.busy   = busy_q;
  assign bus.up_cnt = cnt_q;
  assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_up_cnt_sched.sv
// Table-driven bench for up_cnt_sched; expected outputs go through a scoreboard queue.
// Tie rows follow UP_CNT_SCHED_FIXED_PRIO_EN when it is defined.
module tb_up_cnt_sched;

`ifdef UP_CNT_SCHED_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif

  typedef struct {
    logic       req0;
    logic [2:0] len0;
    logic       req1;
    logic [2:0] len1;
    logic       clear;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic       busy;
    logic [2:0] cnt;
    logic       wrap;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  vec_t sb[$];

  up_cnt_sched_if #(.CNT_W(3), .LEN_W(3)) bus ();

  up_cnt_sched #(.CNT_W(3), .CNT_MAX(6), .LEN_W(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial forever #5 clk = ~clk;

  function automatic vec_t mk(input int r0, input int l0, input int r1, input int l1, input int clr,
                              input int g0, input int g1, input int d0, input int d1,
                              input int bsy, input int c, input int w);
    vec_t v;
    v.req0 = r0[0]; v.len0 = l0[2:0]; v.req1 = r1[0]; v.len1 = l1[2:0]; v.clear = clr[0];
    v.gnt0 = g0[0]; v.gnt1 = g1[0]; v.done0 = d0[0]; v.done1 = d1[0];
    v.busy = bsy[0]; v.cnt = c[2:0]; v.wrap = w[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input vec_t e);
    check({tag, ".gnt0"},  32'(bus.gnt0),   32'(e.gnt0));
    check({tag, ".gnt1"},  32'(bus.gnt1),   32'(e.gnt1));
    check({tag, ".done0"}, 32'(bus.done0),  32'(e.done0));
    check({tag, ".done1"}, 32'(bus.done1),  32'(e.done1));
    check({tag, ".busy"},  32'(bus.busy),   32'(e.busy));
    check({tag, ".cnt"},   32'(bus.up_cnt), 32'(e.cnt));
    check({tag, ".wrap"},  32'(bus.wrap),   32'(e.wrap));
  endtask

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    bus.req0 = v.req0; bus.len0 = v.len0; bus.req1 = v.req1; bus.len1 = v.len1; bus.clear = v.clear;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outs(tag, e);
  endtask

  initial begin
    bus.req0 = 1'b0; bus.len0 = 3'd0; bus.req1 = 1'b0; bus.len1 = 3'd0; bus.clear = 1'b0;

    // single burst, LEN0=3
    tbl.push_back(mk(1,3,0,0,0, 1,0,0,0,1,0,0));
    tbl.push_back(mk(1,3,0,0,0, 1,0,0,0,1,1,0));
    tbl.push_back(mk(1,3,0,0,0, 1,0,0,0,1,2,0));
    tbl.push_back(mk(1,3,0,0,0, 1,0,1,0,1,3,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,3,0));
    // preload to 5
    tbl.push_back(mk(1,2,0,0,0, 1,0,0,0,1,3,0));
    tbl.push_back(mk(1,2,0,0,0, 1,0,0,0,1,4,0));
    tbl.push_back(mk(1,2,0,0,0, 1,0,1,0,1,5,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,5,0));
    // wrap via requester 1
    tbl.push_back(mk(0,0,1,3,0, 0,1,0,0,1,5,0));
    tbl.push_back(mk(0,0,1,3,0, 0,1,0,0,1,6,0));
    tbl.push_back(mk(0,0,1,3,0, 0,1,0,0,1,0,1));
    tbl.push_back(mk(0,0,1,3,0, 0,1,0,1,1,1,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,1,0));
    // tie, both held with LEN=1
    tbl.push_back(mk(1,1,1,1,0, 1,0,0,0,1,1,0));
    tbl.push_back(mk(1,1,1,1,0, 1,0,1,0,1,2,0));
    tbl.push_back(mk(1,1,1,1,0, 0,0,0,0,0,2,0));
    tbl.push_back(mk(1,1,1,1,0, FP,!FP,0,0,1,2,0));
    tbl.push_back(mk(1,1,1,1,0, FP,!FP,FP,!FP,1,3,0));
    tbl.push_back(mk(1,1,1,1,0, 0,0,0,0,0,3,0));
    tbl.push_back(mk(1,1,1,1,0, 1,0,0,0,1,3,0));
    tbl.push_back(mk(1,1,1,1,0, 1,0,1,0,1,4,0));
    tbl.push_back(mk(1,1,1,1,0, 0,0,0,0,0,4,0));
    tbl.push_back(mk(1,1,1,1,0, FP,!FP,0,0,1,4,0));
    tbl.push_back(mk(1,1,1,1,0, FP,!FP,FP,!FP,1,5,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,5,0));
    // clear while idle, then CLEAR on the second RUN cycle of a LEN0=4 burst
    tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,4,0,0,0, 1,0,0,0,1,0,0));
    tbl.push_back(mk(1,4,0,0,0, 1,0,0,0,1,1,0));
    tbl.push_back(mk(1,4,0,0,1, 1,0,0,0,1,0,0));
    tbl.push_back(mk(1,4,0,0,0, 1,0,0,0,1,1,0));
    tbl.push_back(mk(1,4,0,0,0, 1,0,0,0,1,2,0));
    tbl.push_back(mk(1,4,0,0,0, 1,0,1,0,1,3,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,3,0));
    // abort after two increments, then zero-length burst on requester 1
    tbl.push_back(mk(0,0,0,0,1, 0,0,0,0,0,0,0));
    tbl.push_back(mk(1,5,0,0,0, 1,0,0,0,1,0,0));
    tbl.push_back(mk(1,5,0,0,0, 1,0,0,0,1,1,0));
    tbl.push_back(mk(1,5,0,0,0, 1,0,0,0,1,2,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,2,0));
    tbl.push_back(mk(0,0,1,0,0, 0,1,0,1,1,2,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0,0,2,0));

    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", mk(0,0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("row%0d", i));
    end

    // async reset in the middle of a RUN burst
    step(mk(1,5,0,0,0, 1,0,0,0,1,2,0), "rst_a");
    step(mk(1,5,0,0,0, 1,0,0,0,1,3,0), "rst_b");
    step(mk(1,5,0,0,0, 1,0,0,0,1,4,0), "rst_c");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_outs("rst_async", mk(0,0,0,0,0, 0,0,0,0,0,0,0));
    bus.req0 = 1'b0;
    @(posedge clk);
    #1;
    check_outs("rst_held", mk(0,0,0,0,0, 0,0,0,0,0,0,0));
    @(negedge clk);
    rst = 1'b0;
    // first tie after reset goes to requester 0
    step(mk(1,0,1,0,0, 1,0,1,0,1,0,0), "post_rst_tie");
    step(mk(0,0,0,0,0, 0,0,0,0,0,0,0), "post_rst_idle");

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
